menu_controller: RTL and testbench
==================================

# menu_controller

Game-screen sequencer for the VGA front end. It debounces the four player buttons on frame ticks and runs the MENU / HOWTO / PLAY / GAMEOVER state machine. It drives the per-string enables and the selection highlight consumed by `text_layer`, and gates the game-logic run enable. It sits between the button inputs, the game logic and the pixel compositor.

## Interface
Parameters:
- `DEBOUNCE_FRAMES`, 3: consecutive equal frame samples required to accept a button level change (1..15).
- `BLINK_FRAMES`, 30: frames per half-period of the highlight blink (1..255).
- `GAMEOVER_FRAMES`, 180: frames spent in GAMEOVER before auto-return to MENU (1..1023).

Ports:
- `clk` in 1: pixel-domain clock; only clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-`clk` pulse per frame (start of vblank).
- `btn_up`, `btn_down`, `btn_select`, `btn_back` in 1 each: raw button levels, active-high, already synchronous to `clk`.
- `player_dead` in 1: level from game logic, HP reached zero.
- `state` out 2: current screen, encoding from `menu_pkg`.
- `menu_sel` out 1: highlighted item; 0 = START, 1 = HOW TO PLAY.
- `start_en`, `howto_en` out 1 each: compositor enables for `start_text_on` and `howto_text_on`.
- `hud_en` out 1: enable for `score_text_on` and `hp_text_on`.
- `blink_on` out 1: highlight phase for the selected item.
- `game_run` out 1: game-logic advance enable.
- `game_reset` out 1: one-`clk` pulse that clears score and HP.

## Operation
- Debounce, per button: sample only on `frame_tick`. A per-button counter counts consecutive samples that differ from the debounced level. When it reaches `DEBOUNCE_FRAMES`, the debounced level flips and the counter clears. An equal sample clears the counter. A press event is a 0→1 flip of the debounced level, registered as a one-`clk` pulse.
- Event priority within one cycle: select > back > up/down. If up and down press together, neither acts.
- MENU:
  - up → `menu_sel`=0; down → `menu_sel`=1. No wrap; a repeated press is a no-op.
  - select with `menu_sel`=0 → PLAY and pulse `game_reset`.
  - select with `menu_sel`=1 → HOWTO.
- HOWTO: back or select → MENU, with `menu_sel` held at 1.
- PLAY:
  - `player_dead`=1 → GAMEOVER. This has priority over every button event in the same cycle.
  - back → MENU with `menu_sel`=0 (abort).
- GAMEOVER:
  - A frame counter is cleared on entry and increments on each `frame_tick`.
  - At `GAMEOVER_FRAMES`, or on a select press, → MENU with `menu_sel`=0.
- Output decode, all registered from next-state:
  - MENU: `start_en`=`howto_en`=1.
  - HOWTO: `howto_en`=1.
  - PLAY: `hud_en`=1, `game_run`=1.
  - GAMEOVER: `hud_en`=1, `game_run`=0.
- Blink:
  - The counter is cleared and `blink_on`=1 on every entry to MENU.
  - The counter increments per `frame_tick`. At `BLINK_FRAMES` it clears and toggles `blink_on`.
  - Outside MENU, `blink_on`=1.
- Reset values: state=MENU, `menu_sel`=0, `start_en`=`howto_en`=1, `hud_en`=0, `blink_on`=1, `game_run`=0, `game_reset`=0. Debounced levels=0 and all counters=0.

## Timing
- Debounce acceptance: the debounced level flips at the edge closing the `frame_tick` cycle that carries the `DEBOUNCE_FRAMES`-th consecutive sample. The press pulse is high during the following cycle.
- `state` and the decoded outputs update at the edge closing the press-pulse cycle. End-to-end latency is 2 `clk` after that `frame_tick` cycle.
- `game_reset` is high exactly during the first cycle in which `state`=PLAY.
- `player_dead` → GAMEOVER takes 1 `clk`. `game_run` drops in the same cycle that `state` changes.
- A button held across a state change generates no second event; a release must be debounced first.
- Asserting `rst` at any time forces reset values immediately, mid-debounce or mid-GAMEOVER included.
- Counter widths are fixed to the parameter maxima (4, 8 and 10 bits). Counters never wrap, because each clears at its terminal value.

## Structure
- `menu_pkg` holds:
  - state encodings: MENU=2'd0, HOWTO=2'd1, PLAY=2'd2, GAMEOVER=2'd3;
  - item codes: SEL_START=1'b0, SEL_HOWTO=1'b1;
  - counter width constants.
- Sub-module `btn_debounce` (one button: counter, debounced level, press pulse), instantiated four times. The FSM, blink logic and GAMEOVER timer live in `menu_controller`.

## Test plan
- Reset, then `btn_down` held for 3 frames → `menu_sel`=1 exactly 2 `clk` after the third `frame_tick`. Hold for only 2 frames and then release → `menu_sel` stays 0.
- In MENU with `menu_sel`=0, press select → `state`=PLAY, `game_reset` pulses for 1 `clk`, `hud_en`=1, `game_run`=1, `start_en`=0.
- In PLAY, assert `player_dead` in the same cycle as a back press event → GAMEOVER, not MENU. After 180 frame ticks with no input → MENU with `menu_sel`=0.
- In MENU, up and down press on the same frame → `menu_sel` unchanged. Select held from MENU through entry to HOWTO → stays in HOWTO until a release and a new press.
- In MENU, count frames → `blink_on` toggles every 30 `frame_tick`s. Leave to HOWTO and return → `blink_on`=1 and the count restarts.
- Assert `rst` mid-GAMEOVER and mid-debounce → all outputs at reset values the same cycle. After release, the first press still needs 3 full frames.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared types and constants for the game-screen sequencer: screen
// encodings, menu item codes and the fixed counter widths.
package menu_pkg;

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        HOWTO    = 2'd1,
        PLAY     = 2'd2,
        GAMEOVER = 2'd3
    } menu_state_t;

    typedef enum logic {
        SEL_START = 1'b0,
        SEL_HOWTO = 1'b1
    } menu_item_t;

    localparam int DEB_CNT_W   = 4;
    localparam int BLINK_CNT_W = 8;
    localparam int GO_CNT_W    = 10;

endpackage

// File: rtl/menu_controller_if.sv
// Bundle of the button, game-logic and compositor signals around the
// screen sequencer. The controller takes the slave view; whatever drives
// the buttons and consumes the enables takes the master view.
interface menu_controller_if;
    import menu_pkg::*;

    logic        frame_tick;
    logic        btn_up;
    logic        btn_down;
    logic        btn_select;
    logic        btn_back;
    logic        player_dead;

    menu_state_t state;
    logic        menu_sel;
    logic        start_en;
    logic        howto_en;
    logic        hud_en;
    logic        blink_on;
    logic        game_run;
    logic        game_reset;

    modport master (
        output frame_tick, btn_up, btn_down, btn_select, btn_back, player_dead,
        input  state, menu_sel, start_en, howto_en, hud_en, blink_on,
               game_run, game_reset
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_select, btn_back, player_dead,
        output state, menu_sel, start_en, howto_en, hud_en, blink_on,
               game_run, game_reset
    );

endinterface

// File: rtl/menu_controller_btn_debounce.sv
// Frame-rate debouncer for one button. A level change is accepted only
// after enough consecutive frame samples disagree with the current
// debounced level; a rising acceptance produces a one-clock press pulse.
module btn_debounce
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic btn_raw,
    output logic btn_press
);

    logic [DEB_CNT_W-1:0] cnt;
    logic                 level;

    // Count disagreeing frame samples, flip the level on the last one and
    // emit the press pulse in the following cycle when the flip is 0->1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            level     <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            btn_press <= 1'b0;
            if (frame_tick) begin
                if (btn_raw != level) begin
                    if (cnt == DEB_CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                        cnt       <= '0;
                        level     <= btn_raw;
                        btn_press <= btn_raw;
                    end else begin
                        cnt <= cnt + DEB_CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/menu_controller.sv
// Screen sequencer for the VGA front end: debounces the four buttons,
// walks MENU / HOWTO / PLAY / GAMEOVER, blinks the menu highlight and
// gates the game logic. All outputs are registered from the next state.
module menu_controller
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int BLINK_FRAMES    = 30,
    parameter int GAMEOVER_FRAMES = 180
) (
    input logic              clk,
    input logic              rst,
    menu_controller_if.slave bus
);

    logic up_press, down_press, select_press, back_press;

    menu_state_t state_q, state_d;
    menu_item_t  sel_q, sel_d;
    logic        go_expire;

    logic [GO_CNT_W-1:0]    go_cnt;
    logic [BLINK_CNT_W-1:0] blink_cnt;
    logic                   blink_q;

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_up (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick),
        .btn_raw(bus.btn_up), .btn_press(up_press)
    );
    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_down (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick),
        .btn_raw(bus.btn_down), .btn_press(down_press)
    );
    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_select (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick),
        .btn_raw(bus.btn_select), .btn_press(select_press)
    );
    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_back (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick),
        .btn_raw(bus.btn_back), .btn_press(back_press)
    );

    // Next screen and highlighted item; select beats back beats up/down,
    // and a dying player overrides any button while playing.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        go_expire = bus.frame_tick && (go_cnt == GO_CNT_W'(GAMEOVER_FRAMES - 1));
        case (state_q)
            MENU: begin
                if (select_press) begin
                    state_d = (sel_q == SEL_START) ? PLAY : HOWTO;
                end else if (!back_press) begin
                    if (up_press && !down_press) begin
                        sel_d = SEL_START;
                    end else if (down_press && !up_press) begin
                        sel_d = SEL_HOWTO;
                    end
                end
            end
            HOWTO: begin
                if (select_press || back_press) begin
                    state_d = MENU;
                    sel_d   = SEL_HOWTO;
                end
            end
            PLAY: begin
                if (bus.player_dead) begin
                    state_d = GAMEOVER;
                end else if (back_press) begin
                    state_d = MENU;
                    sel_d   = SEL_START;
                end
            end
            GAMEOVER: begin
                if (select_press || go_expire) begin
                    state_d = MENU;
                    sel_d   = SEL_START;
                end
            end
            default: begin
                state_d = MENU;
                sel_d   = SEL_START;
            end
        endcase
    end

    // Register the screen, the item and every decoded enable from the next
    // state so they all change together; game_reset marks the PLAY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= MENU;
            sel_q          <= SEL_START;
            bus.start_en   <= 1'b1;
            bus.howto_en   <= 1'b1;
            bus.hud_en     <= 1'b0;
            bus.game_run   <= 1'b0;
            bus.game_reset <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            bus.start_en   <= (state_d == MENU);
            bus.howto_en   <= (state_d == MENU) || (state_d == HOWTO);
            bus.hud_en     <= (state_d == PLAY) || (state_d == GAMEOVER);
            bus.game_run   <= (state_d == PLAY);
            bus.game_reset <= (state_d == PLAY) && (state_q != PLAY);
        end
    end

    // Count frames spent in GAMEOVER; the count restarts on every entry
    // because it is held at zero whenever we are not staying there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_cnt <= '0;
        end else if (state_q == GAMEOVER && state_d == GAMEOVER) begin
            if (bus.frame_tick) begin
                go_cnt <= go_cnt + GO_CNT_W'(1);
            end
        end else begin
            go_cnt <= '0;
        end
    end

    // Blink the highlight while staying in MENU; any entry to MENU or time
    // spent elsewhere restarts the phase at "on".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (state_q == MENU && state_d == MENU) begin
            if (bus.frame_tick) begin
                if (blink_cnt == BLINK_CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_q   <= ~blink_q;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_CNT_W'(1);
                end
            end
        end else begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end
    end

    assign bus.state    = state_q;
    assign bus.menu_sel = sel_q;
    assign bus.blink_on = blink_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed bench for the screen sequencer: walks the menu, the debounce
// timing, the PLAY/GAMEOVER path, the blink phase and asynchronous reset.
module tb_menu_controller;
    import menu_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    menu_controller_if m ();

    menu_controller #(
        .DEBOUNCE_FRAMES(3),
        .BLINK_FRAMES(30),
        .GAMEOVER_FRAMES(180)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(m.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frameTick();
        m.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        m.frame_tick = 1'b0;
    endtask

    task automatic holdFrames(input int n);
        repeat (n) begin
            frameTick();
            step(1);
        end
    endtask

    task automatic applyStimulus(input logic up, input logic down,
                                 input logic sel, input logic back,
                                 input logic dead);
        m.btn_up      = up;
        m.btn_down    = down;
        m.btn_select  = sel;
        m.btn_back    = back;
        m.player_dead = dead;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence covering every screen and the timing edges.
    initial begin
        vectors     = 0;
        miscompares = 0;
        m.frame_tick = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        step(2);
        checkOutput("rst_state",    8'(m.state), 8'(MENU));
        checkOutput("rst_sel",      8'(m.menu_sel), 8'd0);
        checkOutput("rst_start_en", 8'(m.start_en), 8'd1);
        checkOutput("rst_howto_en", 8'(m.howto_en), 8'd1);
        checkOutput("rst_hud_en",   8'(m.hud_en), 8'd0);
        checkOutput("rst_blink",    8'(m.blink_on), 8'd1);
        checkOutput("rst_run",      8'(m.game_run), 8'd0);
        checkOutput("rst_greset",   8'(m.game_reset), 8'd0);
        rst = 1'b0;
        step(1);

        applyStimulus(0, 1, 0, 0, 0);
        holdFrames(2);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        checkOutput("short_down_sel", 8'(m.menu_sel), 8'd0);

        applyStimulus(0, 1, 0, 0, 0);
        holdFrames(2);
        frameTick();
        checkOutput("down_lat1_sel", 8'(m.menu_sel), 8'd0);
        step(1);
        checkOutput("down_lat2_sel", 8'(m.menu_sel), 8'd1);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);

        applyStimulus(1, 1, 0, 0, 0);
        holdFrames(3);
        checkOutput("updown_sel",   8'(m.menu_sel), 8'd1);
        checkOutput("updown_state", 8'(m.state), 8'(MENU));
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);

        applyStimulus(0, 0, 1, 0, 0);
        holdFrames(3);
        checkOutput("howto_state",    8'(m.state), 8'(HOWTO));
        checkOutput("howto_howto_en", 8'(m.howto_en), 8'd1);
        checkOutput("howto_start_en", 8'(m.start_en), 8'd0);
        checkOutput("howto_blink",    8'(m.blink_on), 8'd1);
        holdFrames(5);
        checkOutput("held_sel_state", 8'(m.state), 8'(HOWTO));
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        checkOutput("release_state", 8'(m.state), 8'(HOWTO));
        applyStimulus(0, 0, 1, 0, 0);
        holdFrames(3);
        checkOutput("howto_ret_state", 8'(m.state), 8'(MENU));
        checkOutput("howto_ret_sel",   8'(m.menu_sel), 8'd1);
        checkOutput("howto_ret_blink", 8'(m.blink_on), 8'd1);

        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        holdFrames(26);
        checkOutput("blink_29", 8'(m.blink_on), 8'd1);
        holdFrames(1);
        checkOutput("blink_30", 8'(m.blink_on), 8'd0);
        holdFrames(29);
        checkOutput("blink_59", 8'(m.blink_on), 8'd0);
        holdFrames(1);
        checkOutput("blink_60", 8'(m.blink_on), 8'd1);
        holdFrames(30);
        checkOutput("blink_90", 8'(m.blink_on), 8'd0);

        applyStimulus(0, 0, 1, 0, 0);
        holdFrames(3);
        checkOutput("leave_state", 8'(m.state), 8'(HOWTO));
        checkOutput("leave_blink", 8'(m.blink_on), 8'd1);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        applyStimulus(0, 0, 0, 1, 0);
        holdFrames(3);
        checkOutput("back_ret_state", 8'(m.state), 8'(MENU));
        checkOutput("back_ret_sel",   8'(m.menu_sel), 8'd1);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        holdFrames(26);
        checkOutput("reblink_29", 8'(m.blink_on), 8'd1);
        holdFrames(1);
        checkOutput("reblink_30", 8'(m.blink_on), 8'd0);

        applyStimulus(1, 0, 0, 0, 0);
        holdFrames(3);
        checkOutput("up_sel", 8'(m.menu_sel), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        applyStimulus(0, 0, 1, 0, 0);
        holdFrames(2);
        frameTick();
        step(1);
        checkOutput("play_state",    8'(m.state), 8'(PLAY));
        checkOutput("play_greset",   8'(m.game_reset), 8'd1);
        checkOutput("play_hud",      8'(m.hud_en), 8'd1);
        checkOutput("play_run",      8'(m.game_run), 8'd1);
        checkOutput("play_start_en", 8'(m.start_en), 8'd0);
        checkOutput("play_howto_en", 8'(m.howto_en), 8'd0);
        step(1);
        checkOutput("play_greset_end", 8'(m.game_reset), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        checkOutput("play_stay", 8'(m.state), 8'(PLAY));

        applyStimulus(0, 0, 0, 1, 0);
        holdFrames(2);
        frameTick();
        applyStimulus(0, 0, 0, 1, 1);
        step(1);
        checkOutput("dead_state", 8'(m.state), 8'(GAMEOVER));
        checkOutput("dead_run",   8'(m.game_run), 8'd0);
        checkOutput("dead_hud",   8'(m.hud_en), 8'd1);
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        holdFrames(176);
        checkOutput("go_179_state", 8'(m.state), 8'(GAMEOVER));
        holdFrames(1);
        checkOutput("go_180_state", 8'(m.state), 8'(MENU));
        checkOutput("go_180_sel",   8'(m.menu_sel), 8'd0);
        checkOutput("go_180_start", 8'(m.start_en), 8'd1);

        applyStimulus(0, 0, 1, 0, 0);
        holdFrames(3);
        checkOutput("play2_state", 8'(m.state), 8'(PLAY));
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(3);
        applyStimulus(0, 0, 0, 0, 1);
        step(1);
        checkOutput("dead2_state", 8'(m.state), 8'(GAMEOVER));
        applyStimulus(0, 0, 0, 0, 0);
        holdFrames(5);
        applyStimulus(0, 1, 0, 0, 0);
        holdFrames(2);
        rst = 1'b1;
        #1;
        checkOutput("arst_state", 8'(m.state), 8'(MENU));
        checkOutput("arst_hud",   8'(m.hud_en), 8'd0);
        checkOutput("arst_start", 8'(m.start_en), 8'd1);
        checkOutput("arst_howto", 8'(m.howto_en), 8'd1);
        checkOutput("arst_sel",   8'(m.menu_sel), 8'd0);
        checkOutput("arst_blink", 8'(m.blink_on), 8'd1);
        step(1);
        rst = 1'b0;
        holdFrames(2);
        checkOutput("post_rst_2f_sel", 8'(m.menu_sel), 8'd0);
        holdFrames(1);
        checkOutput("post_rst_3f_sel", 8'(m.menu_sel), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
